// File: rtl/trng_uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : trng_uart_rx_if
// Description : Byte stream from the UART receiver, with ready/valid handshake
//               and the one-cycle error pulses.
// Revision    : 1.0
// ============================================================================
interface trng_uart_rx_if;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_frame_err;
    logic       o_overrun;

    modport master (
        output o_data,
        output o_valid,
        input  i_ready,
        output o_frame_err,
        output o_overrun
    );

    modport slave (
        input  o_data,
        input  o_valid,
        output i_ready,
        input  o_frame_err,
        input  o_overrun
    );
endinterface
`default_nettype wire

// File: rtl/trng_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : trng_uart_rx
// Description : 8N1 UART receiver with a one-byte holding register, a
//               frame-error pulse and an overrun pulse.
// Revision    : 1.0
// ============================================================================
module trng_uart_rx #(
    parameter int CLKS_PER_BIT = 32
) (
    input  wire logic          CLK,
    input  wire logic          RESET,
    input  wire logic          i_serial_data,
    trng_uart_rx_if.master     bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] c_CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          sync1_q, sync2_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          arm_q, arm_d;
    logic          w_line;
    logic          w_done;

    assign w_line = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        // After a frame error the line must go high again before a new start
        // is accepted, so a held break reports only once.
        arm_d   = arm_q | w_line;
        w_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!w_line && arm_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == c_CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    state_d = w_line ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == c_CNT_FULL) begin
                    cnt_d = '0;
                    shift_d[idx_q] = w_line;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            default: begin
                if (cnt_q == c_CNT_FULL) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (w_line) begin
                        w_done = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                        arm_d  = 1'b0;
                    end
                end
            end
        endcase

        if (valid_q && bus.i_ready) begin
            valid_d = 1'b0;
        end
        if (w_done) begin
            if (!valid_q || bus.i_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            arm_q   <= 1'b1;
        end else begin
            sync1_q <= i_serial_data;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            arm_q   <= arm_d;
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_frame_err = ferr_q;
    assign bus.o_overrun   = ovr_q;
endmodule
`default_nettype wire

// File: tb/tb_trng_uart_rx.sv
`timescale 1ps/1ps
`default_nettype none
// ============================================================================
// Module      : tb_trng_uart_rx
// Description : Directed self-checking bench for trng_uart_rx at 8 clocks/bit.
// Revision    : 1.0
// ============================================================================
module tb_trng_uart_rx;
    localparam int CLKS_PER_BIT = 8;
    localparam int BT           = 80000;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic line = 1'b1;

    trng_uart_rx_if bus ();

    trng_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .i_serial_data (line),
        .bus           (bus)
    );

    always #5000 CLK = ~CLK;

    int tests_run = 0;
    int tests_failed = 0;

    int n_acc = 0, n_vhi = 0, n_ferr = 0, n_ovr = 0;
    logic [7:0] last_acc = 8'h00;

    // Outputs sampled on the falling edge; counters only grow.
    initial forever begin
        @(negedge CLK);
        if (bus.o_valid && bus.i_ready) begin
            n_acc++;
            last_acc = bus.o_data;
        end
        if (bus.o_valid)     n_vhi++;
        if (bus.o_frame_err) n_ferr++;
        if (bus.o_overrun)   n_ovr++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bt, input int idle_bits);
        line = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            line = d[i];
            #(bt);
        end
        line = stop;
        #(bt);
        line = 1'b1;
        for (int i = 0; i < idle_bits; i++) #(bt);
    endtask

    task automatic pulse_reset();
        @(posedge CLK);
        #1 RESET = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    initial begin
        int a0, v0, f0, o0;
        bus.i_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("rst_data",  32'(bus.o_data), 32'h00);
        chk("rst_valid", 32'(bus.o_valid), 0);
        chk("rst_ferr",  32'(bus.o_frame_err), 0);
        chk("rst_ovr",   32'(bus.o_overrun), 0);

        // Single byte, consumer always ready
        a0 = n_acc; v0 = n_vhi; f0 = n_ferr; o0 = n_ovr;
        send_frame(8'hA5, 1'b1, BT, 2);
        repeat (4) @(posedge CLK);
        chk("a5_acc",  32'(n_acc - a0), 1);
        chk("a5_data", 32'(last_acc), 32'hA5);
        chk("a5_vhi",  32'(n_vhi - v0), 1);
        chk("a5_ferr", 32'(n_ferr - f0), 0);
        chk("a5_ovr",  32'(n_ovr - o0), 0);

        // Back-to-back frames into a full holding register
        @(posedge CLK);
        #1 bus.i_ready = 1'b0;
        a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
        send_frame(8'h3C, 1'b1, BT, 0);
        send_frame(8'hC3, 1'b1, BT, 3);
        @(negedge CLK);
        chk("ovr_valid", 32'(bus.o_valid), 1);
        chk("ovr_data",  32'(bus.o_data), 32'h3C);
        chk("ovr_pulse", 32'(n_ovr - o0), 1);
        chk("ovr_ferr",  32'(n_ferr - f0), 0);
        @(posedge CLK);
        #1 bus.i_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("ovr_drain_valid", 32'(bus.o_valid), 0);
        chk("ovr_drain_acc",   32'(n_acc - a0), 1);
        chk("ovr_drain_data",  32'(last_acc), 32'h3C);

        // Bad stop bit, then a good frame
        a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
        send_frame(8'h55, 1'b0, BT, 2);
        repeat (4) @(posedge CLK);
        chk("ferr_pulse", 32'(n_ferr - f0), 1);
        chk("ferr_acc",   32'(n_acc - a0), 0);
        chk("ferr_valid", 32'(bus.o_valid), 0);
        send_frame(8'h01, 1'b1, BT, 2);
        repeat (4) @(posedge CLK);
        chk("after_ferr_acc",  32'(n_acc - a0), 1);
        chk("after_ferr_data", 32'(last_acc), 32'h01);
        chk("after_ferr_ovr",  32'(n_ovr - o0), 0);

        // 3-cycle low glitch on an idle line
        a0 = n_acc; f0 = n_ferr;
        @(posedge CLK);
        #1 line = 1'b0;
        repeat (3) @(posedge CLK);
        #1 line = 1'b1;
        repeat (5) @(posedge CLK);
        chk("glitch_acc",  32'(n_acc - a0), 0);
        chk("glitch_ferr", 32'(n_ferr - f0), 0);
        send_frame(8'h5A, 1'b1, BT, 2);
        repeat (4) @(posedge CLK);
        chk("glitch_next_acc",  32'(n_acc - a0), 1);
        chk("glitch_next_data", 32'(last_acc), 32'h5A);

        // Reset in the middle of bit 4 of 0xFF
        a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
        fork
            send_frame(8'hFF, 1'b1, BT, 2);
            begin
                #(BT * 5 + BT / 2);
                pulse_reset();
            end
        join
        send_frame(8'h0F, 1'b1, BT, 2);
        repeat (4) @(posedge CLK);
        chk("rstmid_acc",  32'(n_acc - a0), 1);
        chk("rstmid_data", 32'(last_acc), 32'h0F);
        chk("rstmid_ferr", 32'(n_ferr - f0), 0);
        chk("rstmid_ovr",  32'(n_ovr - o0), 0);

        // Line rate skewed by +/-3 percent
        a0 = n_acc; f0 = n_ferr;
        send_frame(8'h00, 1'b1, BT * 103 / 100, 2);
        repeat (4) @(posedge CLK);
        chk("slow_acc",  32'(n_acc - a0), 1);
        chk("slow_data", 32'(last_acc), 32'h00);
        send_frame(8'hFF, 1'b1, BT * 97 / 100, 2);
        repeat (4) @(posedge CLK);
        chk("fast_acc",  32'(n_acc - a0), 2);
        chk("fast_data", 32'(last_acc), 32'hFF);
        chk("skew_ferr", 32'(n_ferr - f0), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/trng_uart_rx.md
TRNG_UART_RX -- requirements
Module: trng_uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 32, meaning CLK cycles per serial bit (96 MHz / 3 Mbaud); legal range 4..65535.
REQ-002 The block SHALL have port CLK  input  1  system clock; all state on rising edge.
REQ-003 The block SHALL have port RESET  input  1  reset; synchronous, active-high.
REQ-004 The block SHALL have port i_serial_data  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-005 The block SHALL have port o_data  output  8  received byte; valid while o_valid high.
REQ-006 The block SHALL have port o_valid  output  1  byte available.
REQ-007 The block SHALL have port i_ready  input  1  consumer accepts o_data when high with o_valid on a CLK edge.
REQ-008 The block SHALL have port o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 The block SHALL have port o_overrun  output  1  one-cycle pulse: completed byte dropped because holding register full.

Function
REQ-010 i_serial_data SHALL pass through a 2-flop synchronizer (preset high); all logic SHALL use the synchronized line only.
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP; one bit counter (0..CLKS_PER_BIT-1) and a 3-bit data index.
REQ-012 IDLE: synchronized line low -> START, bit counter cleared.
REQ-013 START: at counter = CLKS_PER_BIT/2-1 (integer division, mid start bit), line high -> IDLE (glitch rejected, no outputs); line low -> DATA, counter cleared, index 0.
REQ-014 DATA: at counter = CLKS_PER_BIT-1, sample line into shift bit [index]; index 7 sampled -> STOP, else index+1; counter cleared.
REQ-015 STOP: at counter = CLKS_PER_BIT-1 (mid stop bit), line high -> byte complete; line low -> o_frame_err high next cycle for exactly 1 cycle, byte discarded; both cases -> IDLE.
REQ-016 Returning to IDLE at mid stop bit SHALL allow a back-to-back start bit to be detected with no lost frame.
REQ-017 A line held low (break) SHALL produce one frame error, then wait in IDLE-START cycling only after line returns high; no o_valid.
REQ-018 Byte complete, holding register empty (o_valid low) or accepted same edge (o_valid & i_ready): o_data loaded, o_valid high from next cycle.
REQ-019 Byte complete, o_valid high and i_ready low: new byte dropped, o_data/o_valid unchanged, o_overrun high next cycle for 1 cycle.
REQ-020 o_valid & i_ready without completion: o_valid low next cycle; o_data holds last value.
REQ-021 o_data SHALL be stable whenever o_valid is high and not being accepted.
REQ-022 Latency: o_valid rises CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 3 cycles (+/-1) after line falling edge at the pin.
REQ-023 o_frame_err and o_overrun SHALL never both pulse for the same frame.

Reset
REQ-024 RESET high SHALL force: state IDLE, counters 0, synchronizer flops 1, o_data 8'h00, o_valid 0, o_frame_err 0, o_overrun 0, effective next edge.
REQ-025 RESET mid-frame SHALL abandon the frame with no output pulse; after release, reception resumes at the next falling edge seen in IDLE (line low at release -> treated as start).

Verification (CLKS_PER_BIT = 8)
REQ-026 Send 8'hA5, i_ready held high -> o_data = 8'hA5, o_valid high 1 cycle, no error pulses.
REQ-027 Send 8'h3C, 8'hC3 back-to-back (one stop bit), i_ready low -> o_valid stays high, o_data = 8'h3C, one o_overrun pulse; raise i_ready -> o_valid low next cycle.
REQ-028 Frame 8'h55 with stop bit low -> one o_frame_err pulse, o_valid stays 0; following valid 8'h01 received correctly.
REQ-029 Low glitch of 3 cycles on idle line -> no o_valid, no error, FSM back in IDLE within 5 cycles.
REQ-030 Assert RESET 1 cycle during bit 4 of 8'hFF, then send 8'h0F -> only 8'h0F reported, no error pulses.
REQ-031 Send 8'h00 and 8'hFF at line rate skewed +/-3% vs. CLKS_PER_BIT -> both bytes received correctly.
